// File: rtl/instruction_encoder.sv
// RV32I field packer: assembles an instruction word from its fields and a format select,
// then buffers the word in a small valid/ready FIFO for the fetch-side consumers.
module instruction_encoder #(
    parameter int XLEN              = 32,
    parameter int REG_FILE_DEPTH    = 32,
    parameter int REG_FILE_ADDR_LEN = $clog2(REG_FILE_DEPTH),
    parameter int FIFO_DEPTH        = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   fmt,
    input  logic [6:0]                   opcode,
    input  logic [2:0]                   funct3,
    input  logic [6:0]                   funct7,
    input  logic [REG_FILE_ADDR_LEN-1:0] rd,
    input  logic [REG_FILE_ADDR_LEN-1:0] rs1,
    input  logic [REG_FILE_ADDR_LEN-1:0] rs2,
    input  logic [XLEN-1:0]              imm,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              instr,
    output logic                         fmt_err,
    output logic [7:0]                   err_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic [XLEN-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  encoded;
    logic             fmt_legal;
    logic             full;
    logic             accept;
    logic             push;
    logic             pop;

    // Field placement; illegal formats produce a word that is never pushed.
    always_comb begin
        encoded   = '0;
        fmt_legal = 1'b1;
        case (fmt)
            FMT_R: encoded = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: encoded = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: encoded = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: encoded = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U: encoded = {imm[31:12], rd, opcode};
            FMT_J: encoded = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: fmt_legal = 1'b0;
        endcase
    end

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign in_ready  = !full;
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && fmt_legal;
    assign pop       = out_valid && out_ready;
    assign instr     = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= encoded;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Error reporting: pulse follows the accept edge, counter saturates at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fmt_err   <= 1'b0;
            err_count <= '0;
        end else begin
            fmt_err <= accept && !fmt_legal;
            if (accept && !fmt_legal && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
